fall_monitor: RTL and testbench
===============================

# fall_monitor

Parametrised fall-detection controller that generalises the single-threshold pillbox fall alarm. It qualifies an impact by requiring N consecutive over-threshold signal-magnitude samples, then observes the wearer for a programmable stillness window, and raises a latched alarm if no activity is reported. The alarm is held until an explicit acknowledge. The block sits between the accelerometer SPI front end (SMV samples and activity interrupt) and the pillbox alarm/buzzer logic.

## Interface
- DATA_W, 32: width of the SMV sample.
- IMPACT_THR, 32'h6000: unsigned impact threshold; a sample counts as a hit when smv_in > IMPACT_THR.
- IMPACT_CNT, 3: number of consecutive valid hits that qualify an impact (1–15).
- TICK_DIV, 10_000: clk cycles per observation tick (≥2).
- STILL_TICKS, 5: observation window length in ticks (1–255).
- COUNT_W, 8: width of the confirmed-fall counter.
- clk, input, 1: the single clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high; has priority over every other input.
- smv_in, input, DATA_W: SMV magnitude, unsigned.
- smv_valid, input, 1: smv_in is a new sample this cycle.
- act_int, input, 1: activity interrupt from the accelerometer, active-high = wearer moving.
- ack, input, 1: alarm acknowledge, sampled only in ALARM.
- alarm, output, 1: high in ALARM.
- observing, output, 1: high in OBSERVE.
- state_o, output, 2: current state encoding.
- fall_count, output, COUNT_W: saturating count of confirmed falls.

## Operation
- States and encodings: IDLE=0, IMPACT=1, OBSERVE=2, ALARM=3. All outputs decode from registered state/counters, so there are no combinational input-to-output paths.
- IDLE: on smv_valid with a hit, load hit_cnt=1. If IMPACT_CNT==1, go to OBSERVE; otherwise go to IMPACT. Cycles with smv_valid=0 are ignored.
- IMPACT: on smv_valid with a hit, increment hit_cnt. When it reaches IMPACT_CNT, go to OBSERVE. On smv_valid without a hit, go to IDLE and clear hit_cnt. Non-valid cycles hold the state.
- OBSERVE: on entry, clear the prescaler and tick_cnt. The prescaler counts 0..TICK_DIV-1, and its terminal count increments tick_cnt. In the cycle where tick_cnt==STILL_TICKS-1 and the prescaler is at terminal count, evaluate act_int:
  - act_int=0: go to ALARM.
  - act_int=1: go to IDLE.
- ALARM: samples are ignored. ack=1 returns to IDLE on the next edge. fall_count increments by 1 on every transition into ALARM and saturates at 2^COUNT_W−1 (no wrap).
- Reset: state=IDLE, hit_cnt=0, prescaler=0, tick_cnt=0, fall_count=0, alarm=0, observing=0, state_o=0. A reset asserted mid-impact, mid-observe or in ALARM aborts immediately with no alarm and no count increment.
- ack outside ALARM has no effect. When ack and reset are asserted together, reset wins.

## Timing
- Hit on a valid sample at edge n: state_o changes at edge n+1.
- Impact qualification: the state becomes OBSERVE one edge after the IMPACT_CNT-th consecutive valid hit.
- Observation window: exactly STILL_TICKS×TICK_DIV cycles in OBSERVE. act_int matters only in the final cycle unless the macro below is defined.
- alarm rises at the edge that ends the window and falls one edge after ack is sampled high.
- fall_count updates on the same edge that alarm rises.

## Configuration
- FALL_MONITOR_ABORT_EN
  - Defined: act_int=1 in any cycle of OBSERVE returns the block to IDLE at the next edge, so any movement cancels the window.
  - Not defined: act_int is evaluated only in the final window cycle, matching the legacy behaviour.

## Test plan
Benches use TICK_DIV=4, STILL_TICKS=5 (20-cycle window) and IMPACT_CNT=3.
- Reset, then 3 valid samples of 32'h7000 followed by act_int=0 for the whole window: OBSERVE 1 edge after the 3rd sample, alarm=1 exactly 20 cycles later, fall_count=1. Assert ack for 1 cycle: IDLE next edge, alarm=0.
- Valid samples 32'h7000, 32'h7000, 32'h5000: return to IDLE after the 3rd sample, never OBSERVE. A sample of exactly 32'h6000 never counts as a hit. Idle cycles (smv_valid=0) between hits do not break the qualifying run.
- Full qualification with act_int=1 on the final window cycle only: IDLE, alarm stays 0, fall_count unchanged. Without the macro, act_int=1 only mid-window still produces an alarm. With FALL_MONITOR_ABORT_EN, the same stimulus returns to IDLE one edge after act_int rises.
- Reset pulsed at window cycle 10 and while in ALARM: all outputs 0 the next edge, fall_count=0. Next, assert ack and reset in the same cycle: reset behaviour applies.
- With COUNT_W=2, trigger 5 alarms (each acknowledged): fall_count reads 1,2,3,3,3 and never wraps.

Source files
------------

// File: rtl/fall_monitor_if.sv
// Sample/alarm bundle between the accelerometer front end and the fall monitor.
// The front end drives samples and acknowledge; the monitor returns its status.
interface fall_monitor_if #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 8
);
  logic [DATA_W-1:0]  smv_in;
  logic               smv_valid;
  logic               act_int;
  logic               ack;
  logic               alarm;
  logic               observing;
  logic [1:0]         state_o;
  logic [COUNT_W-1:0] fall_count;

  modport master (
    output smv_in, smv_valid, act_int, ack,
    input  alarm, observing, state_o, fall_count
  );

  modport slave (
    input  smv_in, smv_valid, act_int, ack,
    output alarm, observing, state_o, fall_count
  );
endinterface

// File: rtl/fall_monitor.sv
// Fall detector: N consecutive impact hits, a stillness window, then a latched alarm until ack.
// Optional FALL_MONITOR_ABORT_EN: any activity during the window cancels it immediately.
//
// state   | meaning
// IDLE    | waiting for the first over-threshold sample
// IMPACT  | counting consecutive valid hits
// OBSERVE | stillness window running (prescaler + tick counter)
// ALARM   | fall confirmed, held until ack
module fall_monitor #(
  parameter int                 DATA_W      = 32,
  parameter logic [DATA_W-1:0]  IMPACT_THR  = DATA_W'(32'h6000),
  parameter int                 IMPACT_CNT  = 3,
  parameter int                 TICK_DIV    = 10_000,
  parameter int                 STILL_TICKS = 5,
  parameter int                 COUNT_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  fall_monitor_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IMPACT  = 2'd1,
    ST_OBSERVE = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_hit_cnt;
  logic [PRE_W-1:0]   r_pre;
  logic [7:0]         r_tick;
  logic [COUNT_W-1:0] r_fall_cnt;

  logic w_hit;
  logic w_pre_tc;
  logic w_final;
  logic w_last_hit;

  assign w_hit      = bus.smv_valid && (bus.smv_in > IMPACT_THR);
  assign w_pre_tc   = (r_pre == PRE_W'(TICK_DIV - 1));
  assign w_final    = w_pre_tc && (r_tick == 8'(STILL_TICKS - 1));
  assign w_last_hit = ((r_hit_cnt + 4'd1) == 4'(IMPACT_CNT));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) w_next = (IMPACT_CNT == 1) ? ST_OBSERVE : ST_IMPACT;
      end
      ST_IMPACT: begin
        if (bus.smv_valid) begin
          if (!w_hit)          w_next = ST_IDLE;
          else if (w_last_hit) w_next = ST_OBSERVE;
        end
      end
      ST_OBSERVE: begin
`ifdef FALL_MONITOR_ABORT_EN
        if (bus.act_int)  w_next = ST_IDLE;
        else if (w_final) w_next = ST_ALARM;
`else
        if (w_final) w_next = bus.act_int ? ST_IDLE : ST_ALARM;
`endif
      end
      ST_ALARM: begin
        if (bus.ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.alarm      = (r_state == ST_ALARM);
    bus.observing  = (r_state == ST_OBSERVE);
    bus.state_o    = r_state;
    bus.fall_count = r_fall_cnt;
  end

  // Window counters stay at zero outside OBSERVE, so entry always starts a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_pre      <= '0;
      r_tick     <= '0;
      r_fall_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   r_hit_cnt <= w_hit ? 4'd1 : 4'd0;
        ST_IMPACT: if (bus.smv_valid) r_hit_cnt <= w_hit ? r_hit_cnt + 4'd1 : 4'd0;
        default:   r_hit_cnt <= '0;
      endcase

      if (r_state == ST_OBSERVE && w_next == ST_OBSERVE) begin
        if (w_pre_tc) begin
          r_pre  <= '0;
          r_tick <= r_tick + 8'd1;
        end else begin
          r_pre  <= r_pre + PRE_W'(1);
        end
      end else begin
        r_pre  <= '0;
        r_tick <= '0;
      end

      if (r_state == ST_OBSERVE && w_next == ST_ALARM && r_fall_cnt != '1)
        r_fall_cnt <= r_fall_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fall_monitor.sv
// Directed bench for fall_monitor: two instances (COUNT_W=8 and COUNT_W=2) share one stimulus.
// Window is TICK_DIV=4 x STILL_TICKS=5 = 20 cycles, IMPACT_CNT=3.
module tb_fall_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] smv_in = '0;
  logic        smv_valid = 1'b0;
  logic        act_int = 1'b0;
  logic        ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fall_monitor_if #(.DATA_W(32), .COUNT_W(8)) bus_a ();
  fall_monitor_if #(.DATA_W(32), .COUNT_W(2)) bus_b ();

  assign bus_a.smv_in = smv_in;  assign bus_b.smv_in = smv_in;
  assign bus_a.smv_valid = smv_valid;  assign bus_b.smv_valid = smv_valid;
  assign bus_a.act_int = act_int;  assign bus_b.act_int = act_int;
  assign bus_a.ack = ack;  assign bus_b.ack = ack;

  fall_monitor #(.DATA_W(32), .IMPACT_THR(32'h6000), .IMPACT_CNT(3), .TICK_DIV(4),
                 .STILL_TICKS(5), .COUNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fall_monitor #(.DATA_W(32), .IMPACT_THR(32'h6000), .IMPACT_CNT(3), .TICK_DIV(4),
                 .STILL_TICKS(5), .COUNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // {state_o, alarm, observing} of the wide instance
  wire [3:0] st_a = {bus_a.state_o, bus_a.alarm, bus_a.observing};
  localparam logic [3:0] S_IDLE = 4'b00_0_0, S_IMP = 4'b01_0_0, S_OBS = 4'b10_0_1, S_ALM = 4'b11_1_0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic sample(input logic [31:0] v);
    smv_valid = 1'b1;
    smv_in    = v;
    cyc();
    smv_valid = 1'b0;
    smv_in    = '0;
  endtask

  task automatic qualify();
    repeat (3) sample(32'h7000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'd0 || bus_b.fall_count !== 2'd0) begin
      n_err++;
      $display("FAIL reset: st=%b cnt=%0d/%0d want st=%b cnt=0/0", st_a, bus_a.fall_count, bus_b.fall_count, S_IDLE);
    end
    exp_cnt = 0;
  endtask

  task automatic test_alarm_ack();
    sample(32'h7000);
    sample(32'h7000);
    n_vec++;
    if (st_a !== S_IMP) begin n_err++; $display("FAIL impact_2hits: st=%b want %b", st_a, S_IMP); end
    sample(32'h7000);
    n_vec++;
    if (st_a !== S_OBS) begin n_err++; $display("FAIL observe_entry: st=%b want %b", st_a, S_OBS); end
    run(4);
    ack = 1'b1;   // ack outside ALARM must be ignored
    cyc();
    ack = 1'b0;
    run(14);
    n_vec++;
    if (st_a !== S_OBS) begin n_err++; $display("FAIL window_19: st=%b want %b", st_a, S_OBS); end
    cyc();
    exp_cnt++;
    n_vec++;
    if (st_a !== S_ALM || bus_a.fall_count !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL window_20_alarm: st=%b cnt=%0d want st=%b cnt=%0d", st_a, bus_a.fall_count, S_ALM, exp_cnt);
    end
    sample(32'h7000);   // samples ignored while in ALARM
    n_vec++;
    if (st_a !== S_ALM) begin n_err++; $display("FAIL alarm_hold: st=%b want %b", st_a, S_ALM); end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL ack_release: st=%b want %b", st_a, S_IDLE); end
  endtask

  task automatic test_non_qualify();
    sample(32'h7000);
    sample(32'h7000);
    sample(32'h5000);
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL low_third: st=%b want %b", st_a, S_IDLE); end
    sample(32'h6000);
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL thr_equal_idle: st=%b want %b", st_a, S_IDLE); end
    sample(32'h7000);
    sample(32'h6000);
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL thr_equal_breaks: st=%b want %b", st_a, S_IDLE); end
  endtask

  task automatic test_gap_and_final_act();
    sample(32'h7000);
    run(3);
    sample(32'h7000);
    run(2);
    n_vec++;
    if (st_a !== S_IMP) begin n_err++; $display("FAIL gap_hold: st=%b want %b", st_a, S_IMP); end
    sample(32'h7000);
    n_vec++;
    if (st_a !== S_OBS) begin n_err++; $display("FAIL gap_qualify: st=%b want %b", st_a, S_OBS); end
    run(19);
    act_int = 1'b1;
    cyc();
    act_int = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL final_act: st=%b cnt=%0d want st=%b cnt=%0d", st_a, bus_a.fall_count, S_IDLE, exp_cnt);
    end
  endtask

  task automatic test_mid_act();
    qualify();
    run(9);
    act_int = 1'b1;
    cyc();
    act_int = 1'b0;
`ifdef FALL_MONITOR_ABORT_EN
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL mid_act_abort: st=%b want %b", st_a, S_IDLE); end
    run(10);
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL mid_act_no_alarm: st=%b cnt=%0d want st=%b cnt=%0d", st_a, bus_a.fall_count, S_IDLE, exp_cnt);
    end
`else
    n_vec++;
    if (st_a !== S_OBS) begin n_err++; $display("FAIL mid_act_ignored: st=%b want %b", st_a, S_OBS); end
    run(10);
    exp_cnt++;
    n_vec++;
    if (st_a !== S_ALM || bus_a.fall_count !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL mid_act_alarm: st=%b cnt=%0d want st=%b cnt=%0d", st_a, bus_a.fall_count, S_ALM, exp_cnt);
    end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
`endif
  endtask

  task automatic test_reset_abort();
    qualify();
    run(9);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid_window: st=%b cnt=%0d want st=%b cnt=0", st_a, bus_a.fall_count, S_IDLE);
    end
    run(15);
    n_vec++;
    if (st_a !== S_IDLE) begin n_err++; $display("FAIL reset_no_late_alarm: st=%b want %b", st_a, S_IDLE); end
    qualify();
    run(20);
    n_vec++;
    if (st_a !== S_ALM || bus_a.fall_count !== 8'd1) begin
      n_err++;
      $display("FAIL re_alarm: st=%b cnt=%0d want st=%b cnt=1", st_a, bus_a.fall_count, S_ALM);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_in_alarm: st=%b cnt=%0d want st=%b cnt=0", st_a, bus_a.fall_count, S_IDLE);
    end
    qualify();
    run(20);
    ack   = 1'b1;
    reset = 1'b1;
    cyc();
    ack   = 1'b0;
    reset = 1'b0;
    n_vec++;
    if (st_a !== S_IDLE || bus_a.fall_count !== 8'd0) begin
      n_err++;
      $display("FAIL ack_and_reset: st=%b cnt=%0d want st=%b cnt=0", st_a, bus_a.fall_count, S_IDLE);
    end
    exp_cnt = 0;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      qualify();
      run(20);
      n_vec++;
      if (bus_a.fall_count !== 8'(i) || bus_b.fall_count !== 2'((i > 3) ? 3 : i)) begin
        n_err++;
        $display("FAIL saturate_%0d: cnt=%0d/%0d want %0d/%0d", i, bus_a.fall_count, bus_b.fall_count,
                 i, (i > 3) ? 3 : i);
      end
      ack = 1'b1;
      cyc();
      ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_alarm_ack();
    test_non_qualify();
    test_gap_and_final_act();
    test_mid_act();
    test_reset_abort();
    test_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
